// File: rtl/qmult_pkg.sv
// Shared constants and types for the Q15 multiplier arbiter.
// Q15 operands in, Q31 products out, fixed 3-stage multiply pipeline.
package qmult_pkg;
  localparam int Q15_W      = 16;
  localparam int Q31_W      = 32;
  localparam int ID_W       = 3;
  localparam int PIPE_DEPTH = 3;

  localparam logic [Q15_W-1:0] Q15_MIN = 16'h8000;
  localparam logic [Q31_W-1:0] Q31_SAT = 32'h7FFF_FFFF;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [Q15_W-1:0] a;
    logic [Q15_W-1:0] b;
  } mult_req_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [Q31_W-1:0] data;
    logic             ovf;
  } mult_rsp_t;
endpackage

// File: rtl/q15_mult_pipe.sv
// 3-stage Q15 x Q15 -> Q31 saturating multiplier with id/valid sideband.
//   stage 1: signed 16x16 product
//   stage 2: doubling into Q31, saturating the single overflow case
//   stage 3: output register
// Ports: clk, reset (async, active low), en (advance all stages),
//        in_valid/in_req (operands + id), out_valid/out_rsp, busy.
module q15_mult_pipe
  import qmult_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  logic      in_valid,
  input  mult_req_t in_req,
  output logic      out_valid,
  output mult_rsp_t out_rsp,
  output logic      busy
);
  logic [PIPE_DEPTH:1]      vld_pipe;
  logic [ID_W-1:0]          s1_id, s2_id;
  logic signed [Q31_W-1:0]  s1_prod;
  logic [Q31_W-1:0]         s2_data;
  logic                     s2_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      s1_id    <= '0;
      s1_prod  <= '0;
      s2_id    <= '0;
      s2_data  <= '0;
      s2_ovf   <= 1'b0;
      out_rsp  <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[PIPE_DEPTH-1:1], in_valid};
      s1_id    <= in_req.id;
      s1_prod  <= $signed(in_req.a) * $signed(in_req.b);
      s2_id    <= s1_id;
      // 0x40000000 only arises from -1.0 * -1.0; doubling it would wrap.
      if (s1_prod == 32'sh4000_0000) begin
        s2_data <= Q31_SAT;
        s2_ovf  <= 1'b1;
      end else begin
        s2_data <= {s1_prod[Q31_W-2:0], 1'b0};
        s2_ovf  <= 1'b0;
      end
      out_rsp  <= '{id: s2_id, data: s2_data, ovf: s2_ovf};
    end
  end

  assign out_valid = vld_pipe[PIPE_DEPTH];
  assign busy      = |vld_pipe;
endmodule

// File: rtl/qmult_arbiter.sv
// Round-robin arbiter feeding one shared Q15 saturating multiplier.
// Ports: clk, reset (async, active low); req_valid/req_ready/req_a/req_b
//        per requester (16-bit slices); rsp_valid/rsp_ready/rsp_id/
//        rsp_data/rsp_ovf result stream; busy (pipeline occupied).
// Optional: QMULT_ARBITER_OVF_COUNT_EN adds ovf_count, a saturating
//           16-bit count of consumed saturated results.
module qmult_arbiter
  import qmult_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [Q15_W*NREQ-1:0]  req_a,
  input  logic [Q15_W*NREQ-1:0]  req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [Q31_W-1:0]       rsp_data,
  output logic                   rsp_ovf,
  output logic                   busy
`ifdef QMULT_ARBITER_OVF_COUNT_EN
  ,
  output logic [15:0]            ovf_count
`endif
);
  logic [NREQ-1:0][Q15_W-1:0] a_v, b_v;
  logic [ID_W-1:0]  ptr, gnt_idx;
  logic             gnt_any, stall, hs;
  logic [NREQ-1:0]  grant;
  logic [Q15_W-1:0] sel_a, sel_b;
  mult_req_t        mreq;
  mult_rsp_t        mrsp;

  assign a_v = req_a;
  assign b_v = req_b;

  // First valid requester at or above ptr, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++)
      for (int i = 0; i < NREQ; i++)
        if (!gnt_any && req_valid[i] && ((int'(ptr) + k) % NREQ == i)) begin
          gnt_any = 1'b1;
          gnt_idx = ID_W'(i);
        end
  end

  always_comb begin
    grant = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt_idx == ID_W'(i)) begin
        grant[i] = gnt_any;
        sel_a    = a_v[i];
        sel_b    = b_v[i];
      end
  end

  assign stall     = rsp_valid & ~rsp_ready;
  // Gated by reset so nothing is offered while reset is held.
  assign req_ready = (reset && !stall) ? grant : '0;
  assign hs        = |req_ready;
  assign mreq      = '{id: gnt_idx, a: sel_a, b: sel_b};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  ptr <= '0;
    else if (hs) ptr <= (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  // Whole pipe freezes on stall; a free output slot lets it advance,
  // so a new result lands in the same cycle the old one is consumed.
  q15_mult_pipe u_pipe (
    .clk       (clk),
    .reset     (reset),
    .en        (~stall),
    .in_valid  (hs),
    .in_req    (mreq),
    .out_valid (rsp_valid),
    .out_rsp   (mrsp),
    .busy      (busy)
  );

  assign rsp_id   = mrsp.id;
  assign rsp_data = mrsp.data;
  assign rsp_ovf  = mrsp.ovf;

`ifdef QMULT_ARBITER_OVF_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ovf_count <= '0;
    else if (rsp_valid && rsp_ready && rsp_ovf && ovf_count != 16'hFFFF)
      ovf_count <= ovf_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_qmult_arbiter.sv
// Scoreboard bench for qmult_arbiter (NREQ=4). Stimulus pushes nothing
// itself; the monitor predicts grants from a round-robin model, queues the
// expected product on each handshake, and checks results when presented.
module tb_qmult_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [16*N-1:0] req_a, req_b;
  logic          rsp_valid, rsp_ready;
  logic [2:0]    rsp_id;
  logic [31:0]   rsp_data;
  logic          rsp_ovf, busy;
`ifdef QMULT_ARBITER_OVF_COUNT_EN
  logic [15:0]   ovf_count;
`endif

  qmult_arbiter #(.NREQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
    .busy(busy)
`ifdef QMULT_ARBITER_OVF_COUNT_EN
    , .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        ovf;
    int          ns_at;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   mptr = 0, ns_cnt = 0;
  longint ovf_model = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Q15*Q15 -> Q31 straight from the number format: value 2*a*b, clipped.
  function automatic exp_t model(int id, logic [15:0] a, logic [15:0] b, int ns);
    exp_t   e;
    longint p;
    p = 2 * longint'($signed(a)) * longint'($signed(b));
    e.id = id;
    e.ns_at = ns;
    if (p > 64'sh7FFF_FFFF) begin
      e.data = 32'h7FFF_FFFF;
      e.ovf  = 1'b1;
    end else begin
      e.data = p[31:0];
      e.ovf  = 1'b0;
    end
    return e;
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    int g, j;
    logic exp_valid, stall_m;
    logic [N-1:0] er;
    exp_t e;
    if (!reset) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_ovf", rsp_ovf, 0);
      q.delete();
      mptr = 0;
      ovf_model = 0;
    end else begin
      chk("busy", busy, q.size() != 0);
      // Front result is on the output once it has seen 3 unstalled cycles.
      exp_valid = (q.size() != 0) && (ns_cnt - q[0].ns_at >= 3);
      chk("rsp_valid", rsp_valid, exp_valid);
      stall_m = exp_valid && !rsp_ready;
      if (exp_valid) begin
        chk("rsp_id", rsp_id, q[0].id);
        chk("rsp_data", rsp_data, q[0].data);
        chk("rsp_ovf", rsp_ovf, q[0].ovf);
        if (rsp_ready) begin
          if (q[0].ovf && ovf_model < 65535) ovf_model++;
          void'(q.pop_front());
        end
      end
      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (mptr + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
      er = '0;
      if (g >= 0 && !stall_m) er[g] = 1'b1;
      chk("req_ready", req_ready, er);
      if (er != 0) begin
        e = model(g, req_a[g*16 +: 16], req_b[g*16 +: 16], ns_cnt);
        q.push_back(e);
        mptr = (g + 1) % N;
      end
      if (!stall_m) ns_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(int i, logic [15:0] a, logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drain();
    int n;
    req_valid = '0;
    rsp_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || busy) && n < 30) begin
      step();
      n++;
    end
    chk("drain_timeout", (q.size() != 0) || busy, 0);
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) step();
    reset = 1'b1;

    // Single request on req0: 0.5 * 0.5.
    req_valid = 4'b0001; set_op(0, 16'h4000, 16'h4000);
    step();
    req_valid = '0;
    repeat (4) step();

    // Saturation corner and its neighbour.
    req_valid = 4'b0010; set_op(1, 16'h8000, 16'h8000);
    step();
    set_op(1, 16'h8000, 16'h7FFF);
    step();
    drain();

    // All four requesters from ptr=0: grants 0,1,2,3,0.
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, rnd_op(), rnd_op());
    req_valid = 4'hF;
    repeat (5) step();
    drain();

    // Three in flight, output blocked ~5 cycles, requester kept pending.
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      set_op(2, rnd_op(), rnd_op());
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();

    // Reset with two results in flight; afterwards ptr restarts at 0.
    req_valid = 4'b0011;
    set_op(0, rnd_op(), rnd_op()); set_op(1, rnd_op(), rnd_op());
    repeat (2) step();
    req_valid = '0;
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    req_valid = 4'hF;
    step();
    drain();

    // Random traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) set_op(i, rnd_op(), rnd_op());
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

`ifdef QMULT_ARBITER_OVF_COUNT_EN
    chk("ovf_count_mid", ovf_count, ovf_model);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("ovf_count_rst", ovf_count, 0);
    set_op(0, 16'h8000, 16'h8000);
    req_valid = 4'b0001;
    repeat (70000) step();
    drain();
    chk("ovf_count_model", ovf_count, ovf_model);
    chk("ovf_count_sat", ovf_count, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/qmult_arbiter.md
QMULT_ARBITER -- requirements
Module: qmult_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-002 SHALL have port clk  input  1  meaning the single clock, rising edge.
REQ-003 SHALL have port reset  input  1  meaning the asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  NREQ  meaning a per-requester operand-pair valid.
REQ-005 SHALL have port req_ready  output  NREQ  meaning a per-requester accept, at most one bit high.
REQ-006 SHALL have port req_a  input  16*NREQ  meaning signed Q15 operand A, slice i for requester i.
REQ-007 SHALL have port req_b  input  16*NREQ  meaning signed Q15 operand B, slice i for requester i.
REQ-008 SHALL have port rsp_valid  output  1  meaning the result is valid.
REQ-009 SHALL have port rsp_ready  input  1  meaning the consumer accepts the result.
REQ-010 SHALL have port rsp_id  output  3  meaning the index of the requester that owns the result.
REQ-011 SHALL have port rsp_data  output  32  meaning the signed Q31 product.
REQ-012 SHALL have port rsp_ovf  output  1  meaning the result was saturated.
REQ-013 SHALL have port busy  output  1  meaning any pipeline stage holds a valid entry.

Function
REQ-014 SHALL grant round-robin: the first requester with req_valid high, searching from pointer ptr upward, wrapping NREQ-1 to 0.
REQ-015 SHALL drive req_ready combinationally as grant AND NOT stall, with stall defined as rsp_valid AND NOT rsp_ready.
REQ-016 SHALL set ptr to (granted index + 1) mod NREQ on each handshake, and SHALL hold ptr otherwise.
REQ-017 SHALL accept at most one operand pair per cycle, giving throughput 1/cycle with no stall.
REQ-018 SHALL present a result accepted in cycle n on rsp_* in cycle n+3 when there are no stalls (stage 1: product; stage 2: doubling/saturation; stage 3: output register).
REQ-019 SHALL carry the valid bit and requester id alongside data through every stage.
REQ-020 SHALL compute rsp_data = 2*a*b (Q15xQ15 to Q31).
REQ-021 SHALL, for a = b = -32768, output 0x7FFFFFFF with rsp_ovf=1; all other results have rsp_ovf=0.
REQ-022 SHALL freeze all stages while stall is high, holding rsp_* stable, with no loss or duplication of results.
REQ-023 SHALL keep rsp_valid high until the cycle in which rsp_ready is sampled high.
REQ-024 SHALL let a new result enter in the same cycle the output is consumed (no bubble).

Reset
REQ-025 SHALL, while reset is low, force ptr=0, all stage valids=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_ovf=0, busy=0 and req_ready=0.
REQ-026 SHALL discard in-flight entries on reset assertion mid-operation, and SHALL accept the first request in the first cycle after deassertion.

Configuration
REQ-027 SHALL, with macro QMULT_ARBITER_OVF_COUNT_EN defined, add output ovf_count (16 bit, reset 0), which increments on each consumed result with rsp_ovf=1 and saturates at 0xFFFF.
REQ-028 SHALL, without QMULT_ARBITER_OVF_COUNT_EN, omit the ovf_count port and its logic entirely.

Structure
REQ-029 SHALL place in shared package qmult_pkg: Q15 width 16, Q31 width 32, constant Q15_MIN=0x8000, constant Q31_SAT=0x7FFFFFFF, and the pipeline depth 3.
REQ-030 SHALL instantiate one sub-module q15_mult_pipe, a 3-stage enable-gated saturating multiplier carrying an id/valid sideband.
REQ-031 SHALL keep the arbiter pointer, grant and stall logic in qmult_arbiter.

Verification
REQ-032 SHALL cover this scenario: req0 only, a=0x4000, b=0x4000, rsp_ready=1 -> cycle n+3: rsp_data=0x20000000, rsp_id=0, rsp_ovf=0.
REQ-033 SHALL cover this scenario: a=b=0x8000 -> rsp_data=0x7FFFFFFF, rsp_ovf=1; a=0x8000, b=0x7FFF -> rsp_data=0x80010000, rsp_ovf=0.
REQ-034 SHALL cover this scenario: all four requesters valid continuously with ptr=0 -> grants in order 0,1,2,3,0, one per cycle, rsp_id following the same order.
REQ-035 SHALL cover this scenario: rsp_ready low for 5 cycles with 3 results in flight -> rsp_* stable, req_ready all 0, then 3 results delivered in order on consecutive cycles.
REQ-036 SHALL cover this scenario: reset asserted with 2 results in flight -> no rsp_valid after reset, ptr=0, busy=0.
REQ-037 SHALL cover this scenario: with QMULT_ARBITER_OVF_COUNT_EN defined, 70000 saturating products -> ovf_count=0xFFFF.
